// File: rtl/lut_ram_pkg.sv
//------------------------------------------------------------------------------
// Module  : lut_ram_pkg
// Brief   : Shared types and geometry defaults for the LUT RAM and its controller.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lut_ram_pkg;

    localparam int LUT_WIDTH = 32;
    localparam int LUT_DEPTH = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// Module  : rr_arb2
// Brief   : Two-input round-robin arbiter; a tie goes to the requester that did
//           not win last time.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       enable_i,
    input  logic       last_winner_i,
    output logic [1:0] gnt_o
);

    // last_winner_i == 1 means requester 1 won last, so requester 0 takes a tie
    assign gnt_o[0] = enable_i & req_i[0] & (~req_i[1] |  last_winner_i);
    assign gnt_o[1] = enable_i & req_i[1] & (~req_i[0] | ~last_winner_i);

endmodule

`default_nettype wire

// File: rtl/lut_ram_ctrl.sv
//------------------------------------------------------------------------------
// Module  : lut_ram_ctrl
// Brief   : LUT RAM write-side controller: clears the RAM after reset or on
//           request, then shares the write port between two requesters.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lut_ram_ctrl
    import lut_ram_pkg::*;
#(
    parameter int WIDTH      = LUT_WIDTH,
    parameter int DEPTH      = LUT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  req0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [WIDTH-1:0]      data0_i,
    output logic                  gnt0_o,
    input  logic                  req1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [WIDTH-1:0]      data1_i,
    output logic                  gnt1_o,
    output logic                  ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [WIDTH-1:0]      ram_wr_data_o,
    output logic                  init_done_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

    ctrl_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  last_winner_q, last_winner_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]      wr_data_q, wr_data_d;
    logic                  init_done_q, init_done_d;

    logic                  arb_en;
    logic [1:0]            arb_gnt;

    assign arb_en = (state_q == RUN) && !clear_i;

    rr_arb2 u_arb (
        .req_i         ({req1_i, req0_i}),
        .enable_i      (arb_en),
        .last_winner_i (last_winner_q),
        .gnt_o         (arb_gnt)
    );

    assign gnt0_o = arb_gnt[0];
    assign gnt1_o = arb_gnt[1];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_winner_d = last_winner_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        init_done_d   = init_done_q;

        case (state_q)
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_ADDR;
                end
            end
            RUN: begin
                if (clear_i) begin
                    // Word 0 is written on the very next edge, so the walk
                    // resumes from word 1 and the clear still spans DEPTH cycles.
                    state_d     = CLEAR;
                    cnt_d       = ONE_ADDR;
                    init_done_d = 1'b0;
                    wr_en_d     = 1'b1;
                    wr_addr_d   = '0;
                    wr_data_d   = '0;
                end else if (arb_gnt[0]) begin
                    wr_en_d       = 1'b1;
                    wr_addr_d     = addr0_i;
                    wr_data_d     = data0_i;
                    last_winner_d = 1'b0;
                end else if (arb_gnt[1]) begin
                    wr_en_d       = 1'b1;
                    wr_addr_d     = addr1_i;
                    wr_data_d     = data1_i;
                    last_winner_d = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CLEAR;
            cnt_q         <= '0;
            last_winner_q <= 1'b1;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            init_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_winner_q <= last_winner_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            init_done_q   <= init_done_d;
        end
    end

    assign ram_wr_en_o   = wr_en_q;
    assign ram_wr_addr_o = wr_addr_q;
    assign ram_wr_data_o = wr_data_q;
    assign init_done_o   = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_lut_ram_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_lut_ram_ctrl
// Brief   : Directed self-checking bench for lut_ram_ctrl with a write scoreboard.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lut_ram_ctrl;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    logic          clk;
    logic          rst_n;
    logic          clear_i;
    logic          req0_i, req1_i;
    logic [AW-1:0] addr0_i, addr1_i;
    logic [W-1:0]  data0_i, data1_i;
    logic          gnt0_o, gnt1_o;
    logic          ram_wr_en_o;
    logic [AW-1:0] ram_wr_addr_o;
    logic [W-1:0]  ram_wr_data_o;
    logic          init_done_o;

    wr_t q[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    lut_ram_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (clear_i),
        .req0_i        (req0_i),
        .addr0_i       (addr0_i),
        .data0_i       (data0_i),
        .gnt0_o        (gnt0_o),
        .req1_i        (req1_i),
        .addr1_i       (addr1_i),
        .data1_i       (data1_i),
        .gnt1_o        (gnt1_o),
        .ram_wr_en_o   (ram_wr_en_o),
        .ram_wr_addr_o (ram_wr_addr_o),
        .ram_wr_data_o (ram_wr_data_o),
        .init_done_o   (init_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    // Advance one clock and check the RAM port against the scoreboard head.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("wr_en",   ram_wr_en_o,   1);
            chk("wr_addr", ram_wr_addr_o, e.addr);
            chk("wr_data", ram_wr_data_o, e.data);
        end else begin
            chk("wr_idle", ram_wr_en_o, 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},   ram_wr_en_o,   0);
        chk({tag, "_addr"}, ram_wr_addr_o, 0);
        chk({tag, "_data"}, ram_wr_data_o, 0);
        chk({tag, "_done"}, init_done_o,   0);
        chk({tag, "_gnt0"}, gnt0_o,        0);
        chk({tag, "_gnt1"}, gnt1_o,        0);
    endtask

    initial begin
        int s0;
        int s1;
        rst_n   = 1'b0;
        clear_i = 1'b0;
        req0_i  = 1'b0;
        req1_i  = 1'b0;
        addr0_i = '0;
        addr1_i = '0;
        data0_i = '0;
        data1_i = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");

        // Reset release: full clear, req1 raised midway must wait for RUN
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) push_wr(AW'(i), '0);
        for (int i = 0; i < D; i++) begin
            tick();
            chk("init_done_clr", init_done_o, (i == D - 1));
            if (i == 20) begin
                req1_i  = 1'b1;
                addr1_i = 5'd3;
                data1_i = 32'hCAFE_0001;
            end
            #1;
            if (i < D - 1) chk("gnt1_in_clear", gnt1_o, 0);
        end
        chk("gnt1_first_run", gnt1_o, 1);
        chk("gnt0_first_run", gnt0_o, 0);
        push_wr(5'd3, 32'hCAFE_0001);
        tick();
        req1_i = 1'b0;

        // Contention: last winner is requester 1, so expect 0,1,0,1
        s0 = 0;
        s1 = 0;
        req0_i = 1'b1;
        req1_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr0_i = AW'(10 + s0);
            data0_i = 32'hA000_0000 + W'(s0);
            addr1_i = AW'(20 + s1);
            data1_i = 32'hB000_0000 + W'(s1);
            #1;
            chk("tie_gnt0", gnt0_o, (k % 2 == 0));
            chk("tie_gnt1", gnt1_o, (k % 2 == 1));
            if (k % 2 == 0) begin
                push_wr(AW'(10 + s0), 32'hA000_0000 + W'(s0));
                s0++;
            end else begin
                push_wr(AW'(20 + s1), 32'hB000_0000 + W'(s1));
                s1++;
            end
            tick();
        end
        req0_i = 1'b0;
        req1_i = 1'b0;

        // Single request from requester 0
        req0_i  = 1'b1;
        addr0_i = 5'd5;
        data0_i = 32'hDEAD_BEEF;
        #1;
        chk("single_gnt0", gnt0_o, 1);
        chk("single_gnt1", gnt1_o, 0);
        push_wr(5'd5, 32'hDEAD_BEEF);
        tick();
        req0_i = 1'b0;
        #1;
        chk("idle_gnt0", gnt0_o, 0);
        tick();

        // clear_i while req1 pending
        req1_i  = 1'b1;
        addr1_i = 5'd9;
        data1_i = 32'h5555_AAAA;
        clear_i = 1'b1;
        #1;
        chk("clear_gnt0", gnt0_o, 0);
        chk("clear_gnt1", gnt1_o, 0);
        for (int i = 0; i < D; i++) push_wr(AW'(i), '0);
        for (int i = 0; i < D; i++) begin
            tick();
            clear_i = 1'b0;
            chk("init_done_reclr", init_done_o, (i == D - 1));
            #1;
            if (i < D - 1) chk("gnt1_in_reclr", gnt1_o, 0);
        end
        chk("gnt1_after_reclr", gnt1_o, 1);
        push_wr(5'd9, 32'h5555_AAAA);
        tick();
        req1_i = 1'b0;

        // Asynchronous reset in the middle of a clear, at cnt = 10
        clear_i = 1'b1;
        for (int i = 0; i < 10; i++) push_wr(AW'(i), '0);
        tick();
        clear_i = 1'b0;
        repeat (9) tick();
        chk("midclr_addr", ram_wr_addr_o, 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        q.delete();
        repeat (2) @(negedge clk);
        chk_all_zero("held_rst");
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) push_wr(AW'(i), '0);
        for (int i = 0; i < D; i++) begin
            tick();
            chk("init_done_rst", init_done_o, (i == D - 1));
        end
        tick();
        chk("scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lut_ram_ctrl.md
# lut_ram_ctrl

Write-side controller for the LUT RAM. After reset, or on request, it sequences a full clear of the RAM. It then shares the single RAM write port between two requesters using a round-robin req/gnt handshake. Reads bypass this block and go straight to the RAM read port.

## Interface
Parameters:
- WIDTH, 32, data width of a RAM word
- DEPTH, 32, number of RAM words (≥2)
- ADDR_WIDTH, $clog2(DEPTH), address width

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous and active-low
- clear_i  in  1  level; start a re-clear when sampled high in RUN
- req0_i  in  1  requester 0 write request; held until granted
- addr0_i  in  ADDR_WIDTH  requester 0 write address
- data0_i  in  WIDTH  requester 0 write data
- gnt0_o  out  1  requester 0 grant, combinational, one cycle per accepted write
- req1_i / addr1_i / data1_i / gnt1_o  requester 1, same as requester 0
- ram_wr_en_o  out  1  registered RAM write enable
- ram_wr_addr_o  out  ADDR_WIDTH  registered RAM write address
- ram_wr_data_o  out  WIDTH  registered RAM write data
- init_done_o  out  1  registered; high when RAM is cleared and grants are possible

## Operation
States:
- CLEAR: walk the counter cnt from 0 to DEPTH-1, one word per cycle.
  - Issue ram write (cnt, 0) each cycle.
  - gnt0_o and gnt1_o are 0.
  - clear_i is ignored.
  - When cnt == DEPTH-1, go to RUN and set init_done_o = 1 on that edge.
- RUN, in priority order:
  - If clear_i = 1: go to CLEAR with cnt = 0, drop init_done_o, issue no grant this cycle.
  - Else if exactly one req is high: grant it.
  - Else if both are high: grant the requester that did not win last. The pointer last_winner updates to the granted requester.
  - A grant registers the winner's addr/data onto the RAM port with ram_wr_en_o = 1 next cycle.
  - With no grant, ram_wr_en_o = 0 next cycle.

Handshake rules:
- Requesters hold req, addr and data stable until they sample gnt high.
- A requester whose req is still high after a grant is treated as making a new request.
- At most one gnt is high per cycle.

Reset:
- Reset (rst_n low, asynchronous) immediately forces state = CLEAR, cnt = 0, last_winner = 1 (so requester 0 wins the first tie).
- Reset forces ram_wr_en_o = 0, ram_wr_addr_o = 0, ram_wr_data_o = 0, init_done_o = 0.
- gnt outputs are 0 while in CLEAR.
- Reset in the middle of CLEAR or RUN abandons the operation in progress; the clear restarts at address 0 after release.

## Timing
- Reset release: the first clear write appears on the RAM port at the 1st posedge after rst_n rises. There are DEPTH consecutive ram_wr_en_o cycles, addresses 0..DEPTH-1 in order.
- init_done_o rises on the same edge that presents the last clear write (addr DEPTH-1).
- Earliest grant: the cycle after init_done_o rises.
- Grant latency: gnt in cycle N (combinational from req) → RAM port driven after edge N+1 → word in memory after edge N+2.
- Sustained throughput: one write per cycle. Under contention the two requesters alternate strictly.
- clear_i in cycle N (RUN):
  - No gnt in cycle N.
  - init_done_o low from edge N+1.
  - The clear write to addr 0 appears at edge N+1.
  - The whole clear takes DEPTH cycles.
- A write granted before clear_i still reaches memory. It can be overwritten later by the clear.

## Structure
- Package lut_ram_pkg:
  - ctrl_state_t enum {CLEAR, RUN}.
  - Shared WIDTH/DEPTH defaults, so the RAM and the controller agree.
- Sub-module rr_arb2: a 2-input round-robin arbiter.
  - Inputs: req[1:0], enable, last_winner register.
  - Outputs: one-hot gnt[1:0].
  - The controller holds the FSM, cnt, and the RAM-port output registers.

## Test plan
- Reset release with DEPTH=32 → 32 back-to-back writes, addr 0..31, data 0; init_done_o = 1 on the edge of addr 31; the memory holds all zeros.
- After init, req0 with addr 5, data 32'hDEADBEEF, for one cycle → gnt0_o in the same cycle; ram_wr_* = (1, 5, DEADBEEF) on the next cycle; mem[5] = DEADBEEF one edge later.
- req0 and req1 held together for 4 cycles, with fresh data each grant → gnt pattern 0,1,0,1; the RAM port shows the matching addr/data one cycle behind.
- req1 raised during CLEAR → no gnt1_o until init_done_o is high; granted in the first RUN cycle.
- clear_i pulsed while req1 is pending → no gnt that cycle; init_done_o drops; 32 clear writes follow; req1 is granted after the re-clear.
- rst_n asserted mid-clear at cnt = 10 → all registered outputs are 0 immediately, with no clock; after release the clear restarts at addr 0.
